// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_pkg
// Brief    : Shared types and width limits for the execute-stage mul/div unit.
// Revision : 1.0
// ============================================================================
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } muldiv_state_e;

    localparam int unsigned c_xlen_min = 8;
    localparam int unsigned c_xlen_max = 64;

    function automatic bit muldiv_xlen_ok(input int unsigned xlen);
        return (xlen >= c_xlen_min) && (xlen <= c_xlen_max);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_div_iter.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_div_iter
// Brief    : Restoring unsigned divider core, one quotient bit per cycle.
// Revision : 1.0
// ============================================================================
module muldiv_div_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int c_cnt_w = $clog2(XLEN);

    logic [XLEN-1:0]    r_rem;
    logic [XLEN-1:0]    r_quo;
    logic [XLEN-1:0]    r_dvs;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_done;

    logic [XLEN-1:0]    w_rem_cur;
    logic [XLEN-1:0]    w_quo_cur;
    logic [XLEN-1:0]    w_dvs_cur;
    logic [XLEN:0]      w_shift;
    logic [XLEN:0]      w_diff;
    logic               w_borrow;
    logic [XLEN-1:0]    w_rem_nxt;
    logic [XLEN-1:0]    w_quo_nxt;

    // The first iteration runs on the start edge straight from the inputs,
    // so the last quotient bit lands XLEN-1 edges after start.
    assign w_rem_cur = start ? '0       : r_rem;
    assign w_quo_cur = start ? dividend : r_quo;
    assign w_dvs_cur = start ? divisor  : r_dvs;

    assign w_shift   = {w_rem_cur, w_quo_cur[XLEN-1]};
    assign w_diff    = w_shift - {1'b0, w_dvs_cur};
    assign w_borrow  = w_diff[XLEN];
    assign w_rem_nxt = w_borrow ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
    assign w_quo_nxt = {w_quo_cur[XLEN-2:0], ~w_borrow};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_dvs  <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (start) begin
            r_rem  <= w_rem_nxt;
            r_quo  <= w_quo_nxt;
            r_dvs  <= divisor;
            r_cnt  <= c_cnt_w'(XLEN - 1);
            r_done <= 1'b0;
        end else if (r_cnt != '0) begin
            r_rem  <= w_rem_nxt;
            r_quo  <= w_quo_nxt;
            r_cnt  <= r_cnt - c_cnt_w'(1);
            if (r_cnt == c_cnt_w'(1)) begin
                r_done <= 1'b1;
            end
        end
    end

    assign done      = r_done;
    assign quotient  = r_quo;
    assign remainder = r_rem;

endmodule
`default_nettype wire

// File: rtl/execute_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : execute_muldiv_unit
// Brief    : RV32M/RV64M multi-cycle multiply/divide unit for the execute stage.
// Revision : 1.0
// ============================================================================
module execute_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MUL_LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_addr_in,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_addr_out,
    output logic            stall
);

    localparam int              c_cnt_max  = (MUL_LATENCY > XLEN) ? MUL_LATENCY : XLEN;
    localparam int              c_cnt_w    = $clog2(c_cnt_max + 1);
    localparam logic [XLEN-1:0] c_most_neg = {1'b1, {(XLEN-1){1'b0}}};

    if (!muldiv_xlen_ok(XLEN) || (MUL_LATENCY < 1)) begin : g_param_check
        $error("execute_muldiv_unit: illegal XLEN or MUL_LATENCY");
    end

    muldiv_state_e      r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [2:0]         r_op;
    logic [XLEN-1:0]    r_rs1;
    logic [XLEN-1:0]    r_rs2;
    logic [XLEN-1:0]    r_result;
    logic [4:0]         r_rd;
    logic               r_out_valid;

    logic               w_accept;
    logic               w_in_signed;
    logic               w_div_zero;
    logic               w_div_ovf;
    logic               w_rs1_neg;
    logic               w_rs2_neg;
    logic [XLEN-1:0]    w_mag1;
    logic [XLEN-1:0]    w_mag2;
    logic               w_div_start;
    logic [XLEN-1:0]    w_special_res;

    assign w_accept    = in_valid & (r_state == S_IDLE) & ~flush;
    assign w_in_signed = ~op[0];
    assign w_div_zero  = (rs2_data == '0);
    assign w_div_ovf   = w_in_signed & (rs1_data == c_most_neg) & (rs2_data == '1);
    assign w_rs1_neg   = w_in_signed & rs1_data[XLEN-1];
    assign w_rs2_neg   = w_in_signed & rs2_data[XLEN-1];
    assign w_mag1      = w_rs1_neg ? (-rs1_data) : rs1_data;
    assign w_mag2      = w_rs2_neg ? (-rs2_data) : rs2_data;
    assign w_div_start = w_accept & op[2] & ~w_div_zero & ~w_div_ovf;

    // op[1] selects remainder; overflow only reaches here for signed ops.
    assign w_special_res = w_div_zero ? (op[1] ? rs1_data : '1)
                                      : (op[1] ? '0       : rs1_data);

    // Multiplier: sign/zero extension to 2*XLEN makes one unsigned multiply
    // exact for all three signedness combinations modulo 2^(2*XLEN).
    logic                w_a_sgn;
    logic                w_b_sgn;
    logic [2*XLEN-1:0]   w_a_wide;
    logic [2*XLEN-1:0]   w_b_wide;
    logic [2*XLEN-1:0]   w_prod;
    logic [2*XLEN-1:0]   w_mul_tap;
    logic [XLEN-1:0]     w_mul_res;

    assign w_a_sgn  = r_rs1[XLEN-1] & (r_op[1:0] != 2'b11);
    assign w_b_sgn  = r_rs2[XLEN-1] & ~r_op[1];
    assign w_a_wide = {{XLEN{w_a_sgn}}, r_rs1};
    assign w_b_wide = {{XLEN{w_b_sgn}}, r_rs2};
    assign w_prod   = w_a_wide * w_b_wide;

    if (MUL_LATENCY == 1) begin : g_mul_direct
        assign w_mul_tap = w_prod;
    end else begin : g_mul_pipe
        logic [2*XLEN-1:0] r_pipe [MUL_LATENCY-1];

        always_ff @(posedge clk) begin
            r_pipe[0] <= w_prod;
            for (int i = 1; i < MUL_LATENCY - 1; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end

        assign w_mul_tap = r_pipe[MUL_LATENCY-2];
    end

    assign w_mul_res = (r_op == OP_MUL) ? w_mul_tap[XLEN-1:0] : w_mul_tap[2*XLEN-1:XLEN];

    logic               w_div_done;
    logic [XLEN-1:0]    w_quo_mag;
    logic [XLEN-1:0]    w_rem_mag;
    logic               w_q_neg;
    logic               w_r_neg;
    logic [XLEN-1:0]    w_div_res;

    muldiv_div_iter #(
        .XLEN (XLEN)
    ) u_div_iter (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (w_div_start),
        .dividend  (w_mag1),
        .divisor   (w_mag2),
        .done      (w_div_done),
        .quotient  (w_quo_mag),
        .remainder (w_rem_mag)
    );

    assign w_q_neg   = ~r_op[0] & (r_rs1[XLEN-1] ^ r_rs2[XLEN-1]);
    assign w_r_neg   = ~r_op[0] & r_rs1[XLEN-1];
    assign w_div_res = r_op[1] ? (w_r_neg ? (-w_rem_mag) : w_rem_mag)
                               : (w_q_neg ? (-w_quo_mag) : w_quo_mag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_op        <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_result    <= '0;
            r_rd        <= '0;
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op  <= op;
                        r_rs1 <= rs1_data;
                        r_rs2 <= rs2_data;
                        r_rd  <= rd_addr_in;
                        if (!op[2]) begin
                            r_state <= S_MUL;
                            r_cnt   <= c_cnt_w'(MUL_LATENCY);
                        end else if (w_div_zero || w_div_ovf) begin
                            r_state     <= S_DONE;
                            r_result    <= w_special_res;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= S_DIV;
                            r_cnt   <= c_cnt_w'(XLEN);
                        end
                    end
                end
                S_MUL: begin
                    r_cnt <= r_cnt - c_cnt_w'(1);
                    if (r_cnt == c_cnt_w'(1)) begin
                        r_state     <= S_DONE;
                        r_result    <= w_mul_res;
                        r_out_valid <= 1'b1;
                    end
                end
                S_DIV: begin
                    r_cnt <= r_cnt - c_cnt_w'(1);
                    if ((r_cnt == c_cnt_w'(1)) && w_div_done) begin
                        r_state     <= S_DONE;
                        r_result    <= w_div_res;
                        r_out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign stall       = in_valid & ~in_ready;
    assign out_valid   = r_out_valid;
    assign result      = r_result;
    assign rd_addr_out = r_rd;

endmodule
`default_nettype wire

// File: tb/tb_execute_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_execute_muldiv_unit
// Brief    : Self-checking bench: directed cases plus randomized ops vs model.
// Revision : 1.0
// ============================================================================
module tb_execute_muldiv_unit;

    localparam int XLEN        = 32;
    localparam int MUL_LATENCY = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rd_addr_in;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_addr_out;
    logic            stall;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    execute_muldiv_unit #(
        .XLEN        (XLEN),
        .MUL_LATENCY (MUL_LATENCY)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .rd_addr_in  (rd_addr_in),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .rd_addr_out (rd_addr_out),
        .stall       (stall)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // RISC-V M-extension semantics computed with 64-bit arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        longint    sa;
        longint    sb;
        longint    ua;
        longint    ub;
        logic [63:0] p;
        logic      ovf;
        sa  = $signed(a);
        sb  = $signed(b);
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf)    return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf)    return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] o, input logic [31:0] a,
                                       input logic [31:0] b);
        if (!o[2]) return MUL_LATENCY + 1;
        if (b == 0) return 1;
        if (!o[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
        return XLEN + 1;
    endfunction

    // Presents one op at a negedge; returns at the negedge of cycle 1.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        int w = 0;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("issue_ready", in_ready, 1);
        in_valid   = 1'b1;
        op         = o;
        rs1_data   = a;
        rs2_data   = b;
        rd_addr_in = rd;
        @(posedge clk);
        @(negedge clk);
        in_valid   = 1'b0;
        rs1_data   = $urandom;
        rs2_data   = $urandom;
        rd_addr_in = 5'($urandom);
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (!out_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                          input int hold);
        int cyc;
        logic [31:0] held;
        issue(o, a, b, rd);
        wait_valid(cyc);
        check({tag, "_latency"}, 64'(cyc), 64'(ref_latency(o, a, b)));
        check({tag, "_result"}, result, exp);
        check({tag, "_rd"}, rd_addr_out, rd);
        held = result;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold"}, {out_valid, result}, {1'b1, held});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_retire"}, {in_ready, out_valid}, 2'b10);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        int          rises;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] held;
        logic [2:0]  o;
        logic [4:0]  rd;

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        op         = 3'd0;
        rs1_data   = '0;
        rs2_data   = '0;
        rd_addr_in = '0;
        flush      = 1'b0;
        out_ready  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_state", {in_ready, out_valid, stall, rd_addr_out, result},
              {1'b1, 1'b0, 1'b0, 5'd0, 32'd0});
        rst_n = 1'b1;

        run_op("mul",     3'd0, 32'd7,          32'hFFFF_FFFD, 5'd11, 32'hFFFF_FFEB, 1);
        run_op("mulhu",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE, 0);
        run_op("mulh",    3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'h0000_0000, 0);
        run_op("mulhsu",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 0);
        run_op("div",     3'd4, 32'hFFFF_FFF9, 32'd2,         5'd4,  32'hFFFF_FFFD, 0);
        run_op("rem",     3'd6, 32'hFFFF_FFF9, 32'd2,         5'd5,  32'hFFFF_FFFF, 0);
        run_op("divu",    3'd5, 32'd100,       32'd7,         5'd6,  32'd14,        0);
        run_op("divu_z",  3'd5, 32'd5,         32'd0,         5'd7,  32'hFFFF_FFFF, 0);
        run_op("rem_z",   3'd6, 32'd5,         32'd0,         5'd8,  32'd5,         0);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9,  32'h8000_0000, 0);
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'd0,         0);

        // Flush part-way through a divide.
        issue(3'd4, 32'd1000, 32'd3, 5'd12);
        for (int i = 2; i <= 10; i++) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_div_idle", {in_ready, out_valid}, 2'b10);
        rises = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) rises++;
        end
        check("flush_div_no_valid", 64'(rises), 0);
        run_op("mul_after_flush", 3'd0, 32'd12345, 32'd678, 5'd13, 32'd8369910, 0);

        // Back-pressure in DONE with a new request waiting.
        issue(3'd0, 32'd9, 32'd9, 5'd14);
        wait_valid(cyc);
        check("bp_latency", 64'(cyc), MUL_LATENCY + 1);
        held     = result;
        in_valid = 1'b1;
        op       = 3'd5;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_stable", {result, rd_addr_out, out_valid}, {held, 5'd14, 1'b1});
            check("bp_ready_stall", {in_ready, stall}, 2'b01);
        end
        check("bp_result", held, 32'd81);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_retire", {in_ready, out_valid}, 2'b10);

        // Flush wins over out_ready while a result is held.
        issue(3'd0, 32'd3, 32'd5, 5'd15);
        wait_valid(cyc);
        flush     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        flush     = 1'b0;
        out_ready = 1'b0;
        check("flush_done", {in_ready, out_valid}, 2'b10);

        // Asynchronous reset in the middle of a divide.
        run_op("pre_reset_mul", 3'd0, 32'd6, 32'd7, 5'd16, 32'd42, 0);
        issue(3'd5, 32'd77, 32'd5, 5'd17);
        for (int i = 0; i < 8; i++) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check("async_reset", {out_valid, rd_addr_out, result, in_ready},
                 {1'b0, 5'd0, 32'd0, 1'b1});
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 150; n++) begin
            o  = 3'($urandom_range(0, 7));
            rd = 5'($urandom);
            case ($urandom_range(0, 7))
                0:       a = 32'd0;
                1:       a = 32'hFFFF_FFFF;
                2:       a = 32'h8000_0000;
                3:       a = 32'($urandom_range(0, 15));
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'h8000_0000;
                3:       b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            run_op("rand", o, a, b, rd, ref_result(o, a, b), $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
